// File: rtl/pci_device_controller.sv
// Simplified PCI-style bus agent: a master that runs single or burst
// read/write transactions on request, and a target that serves a small
// word memory when its own 2-bit ID is addressed. All shared lines are
// driven only while the matching output-enable register is set.
module pci_device_controller #(
  parameter int MEM_DEPTH      = 4,
  parameter int DEVSEL_TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        reset_add_n,
  input  logic [1:0]  address,
  input  logic [3:0]  be,
  input  logic        force_req,
  input  logic        rd_wr,
  input  logic [31:0] data,
  input  logic        burst,
  inout  wire  [31:0] ad,
  inout  wire  [3:0]  c_be,
  inout  wire         devsel,
  inout  wire         frame,
  inout  wire         irdy,
  inout  wire         trdy,
  input  logic        gnt,
  output logic        req
);
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int TO_W  = $clog2(DEVSEL_TIMEOUT + 1);
  localparam logic [3:0] CMD_READ  = 4'b0110;
  localparam logic [3:0] CMD_WRITE = 4'b0111;

  typedef enum logic [2:0] {M_IDLE, M_REQ, M_ADDR, M_DATA, M_TURN} m_state_t;
  typedef enum logic [1:0] {T_IDLE, T_CLAIM, T_DATA, T_TURN} t_state_t;

  // Master state and bus drive registers
  m_state_t         m_state;
  logic [1:0]       tgt_id;
  logic             m_read;
  logic             m_burst;
  logic             dev_seen;
  logic             aborting;
  logic [TO_W-1:0]  to_cnt;
  logic             m_frame_oe, m_frame_out;
  logic             m_irdy_oe, m_irdy_out;
  logic             m_ad_oe, m_cbe_oe;
  logic [31:0]      m_ad_out;
  logic [3:0]       m_cbe_out;
  logic [31:0]      last_read;

  // Target state, memory and bus drive registers
  t_state_t         t_state;
  logic [1:0]       own_id;
  logic             frame_prev;
  logic             t_read;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_inc;
  logic             t_devsel_oe, t_devsel_out;
  logic             t_trdy_oe, t_trdy_out;
  logic             t_ad_oe;
  logic [31:0]      t_ad_out;
  logic [31:0]      mem [MEM_DEPTH];

  logic             addr_hit;
  logic             t_xfer;
  logic [31:0]      wmask;

  // Shared-line drivers; master and target of one instance never drive ad together
  assign ad     = (m_ad_oe | t_ad_oe) ? (m_ad_oe ? m_ad_out : t_ad_out) : 32'bz;
  assign c_be   = m_cbe_oe    ? m_cbe_out    : 4'bz;
  assign frame  = m_frame_oe  ? m_frame_out  : 1'bz;
  assign irdy   = m_irdy_oe   ? m_irdy_out   : 1'bz;
  assign devsel = t_devsel_oe ? t_devsel_out : 1'bz;
  assign trdy   = t_trdy_oe   ? t_trdy_out   : 1'bz;

  // Burst index wraps at the end of the memory
  assign idx_inc = (idx == IDX_W'(MEM_DEPTH - 1)) ? '0 : idx + 1'b1;

  // Address phase aimed at us, excluding transactions issued by our own master
  assign addr_hit = frame_prev && !frame && (ad[1:0] == own_id) &&
                    ((c_be == CMD_READ) || (c_be == CMD_WRITE)) && (m_state != M_ADDR);

  // A data transfer completes when both ready lines are low while we are claimed
  assign t_xfer = ((t_state == T_CLAIM) || (t_state == T_DATA)) &&
                  t_trdy_oe && !t_trdy_out && !irdy;

  // Byte-lane write mask from the data-phase byte enables
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_mask
      assign wmask[8*gi +: 8] = {8{c_be[gi]}};
    end
  endgenerate

  // Master FSM: request, address phase, data phases, master abort, turnaround
  always_ff @(posedge clk or negedge reset_add_n) begin
    if (!reset_add_n) begin
      m_state     <= M_IDLE;
      req         <= 1'b1;
      tgt_id      <= 2'b00;
      m_read      <= 1'b0;
      m_burst     <= 1'b0;
      dev_seen    <= 1'b0;
      aborting    <= 1'b0;
      to_cnt      <= '0;
      m_frame_oe  <= 1'b0;
      m_frame_out <= 1'b1;
      m_irdy_oe   <= 1'b0;
      m_irdy_out  <= 1'b1;
      m_ad_oe     <= 1'b0;
      m_cbe_oe    <= 1'b0;
      m_ad_out    <= '0;
      m_cbe_out   <= '0;
      last_read   <= '0;
    end else begin
      case (m_state)
        M_IDLE: if (force_req) begin
          tgt_id  <= address;
          m_read  <= rd_wr;
          m_burst <= burst;
          req     <= 1'b0;
          m_state <= M_REQ;
        end
        M_REQ: if (!gnt && frame && irdy) begin
          req         <= 1'b1;
          m_frame_oe  <= 1'b1;
          m_frame_out <= 1'b0;
          m_ad_oe     <= 1'b1;
          m_ad_out    <= {30'b0, tgt_id};
          m_cbe_oe    <= 1'b1;
          m_cbe_out   <= m_read ? CMD_READ : CMD_WRITE;
          m_state     <= M_ADDR;
        end
        M_ADDR: begin
          m_irdy_oe   <= 1'b1;
          m_irdy_out  <= 1'b0;
          m_frame_out <= !m_burst;
          m_ad_oe     <= !m_read;
          m_ad_out    <= data;
          m_cbe_out   <= be;
          dev_seen    <= 1'b0;
          aborting    <= 1'b0;
          to_cnt      <= '0;
          m_state     <= M_DATA;
        end
        M_DATA: begin
          if (aborting) begin
            m_irdy_out <= 1'b1;
            m_ad_oe    <= 1'b0;
            m_cbe_oe   <= 1'b0;
            m_state    <= M_TURN;
          end else if (!trdy && !devsel) begin
            dev_seen <= 1'b1;
            if (m_read) last_read <= ad;
            if (m_frame_out) begin
              m_irdy_out <= 1'b1;
              m_ad_oe    <= 1'b0;
              m_cbe_oe   <= 1'b0;
              m_state    <= M_TURN;
            end else begin
              m_frame_out <= !burst;
              m_ad_out    <= data;
              m_cbe_out   <= be;
            end
          end else if (!devsel) begin
            dev_seen <= 1'b1;
          end else if (!dev_seen) begin
            if (to_cnt == TO_W'(DEVSEL_TIMEOUT - 1)) begin
              aborting    <= 1'b1;
              m_frame_out <= 1'b1;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
        end
        M_TURN: begin
          m_frame_oe <= 1'b0;
          m_irdy_oe  <= 1'b0;
          m_state    <= M_IDLE;
        end
        default: m_state <= M_IDLE;
      endcase
    end
  end

  // Target FSM: claim on own ID, serve memory reads/writes, turnaround
  always_ff @(posedge clk or negedge reset_add_n) begin
    if (!reset_add_n) begin
      own_id       <= address;
      t_state      <= T_IDLE;
      frame_prev   <= 1'b1;
      t_read       <= 1'b0;
      idx          <= '0;
      t_devsel_oe  <= 1'b0;
      t_devsel_out <= 1'b1;
      t_trdy_oe    <= 1'b0;
      t_trdy_out   <= 1'b1;
      t_ad_oe      <= 1'b0;
      t_ad_out     <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else begin
      frame_prev <= frame;
      case (t_state)
        T_IDLE: if (addr_hit) begin
          idx          <= '0;
          t_read       <= !c_be[0];
          t_devsel_oe  <= 1'b1;
          t_devsel_out <= 1'b0;
          t_trdy_oe    <= 1'b1;
          t_trdy_out   <= !c_be[0];
          t_state      <= T_CLAIM;
        end
        T_CLAIM, T_DATA: begin
          if (t_xfer) begin
            if (!t_read) mem[idx] <= (mem[idx] & ~wmask) | (ad & wmask);
            idx <= idx_inc;
            if (frame) begin
              t_devsel_out <= 1'b1;
              t_trdy_out   <= 1'b1;
              t_ad_oe      <= 1'b0;
              t_state      <= T_TURN;
            end else begin
              if (t_read) t_ad_out <= mem[idx_inc];
              t_state <= T_DATA;
            end
          end else if (frame && irdy) begin
            t_devsel_out <= 1'b1;
            t_trdy_out   <= 1'b1;
            t_ad_oe      <= 1'b0;
            t_state      <= T_TURN;
          end else if (t_state == T_CLAIM) begin
            if (t_read) begin
              t_trdy_out <= 1'b0;
              t_ad_oe    <= 1'b1;
              t_ad_out   <= mem[idx];
            end
            t_state <= T_DATA;
          end
        end
        T_TURN: begin
          t_devsel_oe <= 1'b0;
          t_trdy_oe   <= 1'b0;
          t_state     <= T_IDLE;
        end
        default: t_state <= T_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pci_device_controller.sv
// Three agents (IDs 0, 1, 2) on one pulled-up bus with a fixed-priority
// arbiter; directed scenarios with hand-computed expectations.
module tb_pci_device_controller;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_add_n;
  logic [1:0]  address   [3];
  logic [3:0]  be        [3];
  logic        force_req [3];
  logic        rd_wr     [3];
  logic [31:0] data      [3];
  logic        burst     [3];
  logic [2:0]  gnt;
  wire  [2:0]  req;

  wire [31:0] ad;
  wire [3:0]  c_be;
  wire        devsel, frame, irdy, trdy;
  pullup (devsel);
  pullup (frame);
  pullup (irdy);
  pullup (trdy);

  int passed = 0;
  int total  = 0;

  pci_device_controller dev0 (
    .clk(clk), .reset_add_n(reset_add_n), .address(address[0]), .be(be[0]),
    .force_req(force_req[0]), .rd_wr(rd_wr[0]), .data(data[0]), .burst(burst[0]),
    .ad(ad), .c_be(c_be), .devsel(devsel), .frame(frame), .irdy(irdy), .trdy(trdy),
    .gnt(gnt[0]), .req(req[0]));

  pci_device_controller dev1 (
    .clk(clk), .reset_add_n(reset_add_n), .address(address[1]), .be(be[1]),
    .force_req(force_req[1]), .rd_wr(rd_wr[1]), .data(data[1]), .burst(burst[1]),
    .ad(ad), .c_be(c_be), .devsel(devsel), .frame(frame), .irdy(irdy), .trdy(trdy),
    .gnt(gnt[1]), .req(req[1]));

  pci_device_controller dev2 (
    .clk(clk), .reset_add_n(reset_add_n), .address(address[2]), .be(be[2]),
    .force_req(force_req[2]), .rd_wr(rd_wr[2]), .data(data[2]), .burst(burst[2]),
    .ad(ad), .c_be(c_be), .devsel(devsel), .frame(frame), .irdy(irdy), .trdy(trdy),
    .gnt(gnt[2]), .req(req[2]));

  // Central arbiter: holds grant while the owner keeps REQ# low, else lowest index wins
  logic [1:0] owner;
  logic       owner_v;
  always @(posedge clk or negedge reset_add_n) begin
    if (!reset_add_n) begin
      gnt <= 3'b111; owner <= 2'd0; owner_v <= 1'b0;
    end else if (!(owner_v && !req[owner])) begin
      gnt <= 3'b111; owner_v <= 1'b0;
      if (!req[0])      begin gnt <= 3'b110; owner <= 2'd0; owner_v <= 1'b1; end
      else if (!req[1]) begin gnt <= 3'b101; owner <= 2'd1; owner_v <= 1'b1; end
      else if (!req[2]) begin gnt <= 3'b011; owner <= 2'd2; owner_v <= 1'b1; end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_txn(input int k, input logic [1:0] tgt, input logic rw,
                           input logic [3:0] b, input logic [31:0] d, input logic bst);
    address[k] = tgt; rd_wr[k] = rw; be[k] = b; data[k] = d; burst[k] = bst;
    force_req[k] = 1'b1;
  endtask

  // Returns at the negedge inside the address phase, or n = -1 on timeout
  task automatic wait_addr(output int n);
    n = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) force_req[k] = 1'b0;
      if (frame === 1'b0) begin n = i; break; end
    end
  endtask

  task automatic test_reset;
    reset_add_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      address[k] = 2'(k); be[k] = 4'h0; force_req[k] = 1'b0;
      rd_wr[k] = 1'b0; data[k] = '0; burst[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    total++; if (req !== 3'b111) $display("FAIL reset_req got=%b exp=111", req); else passed++;
    total++; if (frame !== 1'b1 || irdy !== 1'b1) $display("FAIL reset_frame_irdy got=%b%b exp=11", frame, irdy); else passed++;
    total++; if (devsel !== 1'b1 || trdy !== 1'b1) $display("FAIL reset_devsel_trdy got=%b%b exp=11", devsel, trdy); else passed++;
    total++; if (dev1.mem[0] !== 32'h0) $display("FAIL reset_mem got=%h exp=0", dev1.mem[0]); else passed++;
    reset_add_n = 1'b1;
    @(negedge clk);
    total++; if (dev1.own_id !== 2'd1 || dev2.own_id !== 2'd2) $display("FAIL reset_own_id got=%0d,%0d exp=1,2", dev1.own_id, dev2.own_id); else passed++;
  endtask

  task automatic test_self_abort;
    int n, cnt;
    bit dv;
    start_txn(1, 2'd1, 1'b0, 4'hF, 32'hAAAAAAAA, 1'b0);
    wait_addr(n);
    total++; if (n < 0) $display("FAIL self_addr_timeout got=%0d exp>=0", n); else passed++;
    total++; if (ad !== 32'h1 || c_be !== 4'b0111) $display("FAIL self_addr_phase got=%h/%b exp=00000001/0111", ad, c_be); else passed++;
    total++; if (req[1] !== 1'b1) $display("FAIL self_req_release got=%b exp=1", req[1]); else passed++;
    cnt = 0; dv = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (devsel === 1'b0) dv = 1'b1;
      if (irdy === 1'b0) cnt++; else break;
    end
    total++; if (cnt !== 5) $display("FAIL self_abort_irdy_phases got=%0d exp=5", cnt); else passed++;
    total++; if (dv !== 1'b0) $display("FAIL self_claim got=%b exp=0", dv); else passed++;
    total++; if (frame !== 1'b1 || dev1.m_frame_oe !== 1'b1) $display("FAIL self_turn got=%b/%b exp=1/1", frame, dev1.m_frame_oe); else passed++;
    @(negedge clk);
    total++; if (dev1.m_frame_oe !== 1'b0 || dev1.m_irdy_oe !== 1'b0) $display("FAIL self_release got=%b%b exp=00", dev1.m_frame_oe, dev1.m_irdy_oe); else passed++;
    total++; if (dev1.mem[0] !== 32'h0) $display("FAIL self_mem got=%h exp=0", dev1.mem[0]); else passed++;
  endtask

  task automatic test_burst_write;
    int n, xfers;
    start_txn(0, 2'd1, 1'b0, 4'hF, 32'hAAAAAAAA, 1'b1);
    wait_addr(n);
    total++; if (n < 0) $display("FAIL burst_addr_timeout got=%0d exp>=0", n); else passed++;
    total++; if (ad !== 32'h1 || c_be !== 4'b0111) $display("FAIL burst_addr_phase got=%h/%b exp=00000001/0111", ad, c_be); else passed++;
    xfers = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) begin
        total++; if (devsel !== 1'b0 || trdy !== 1'b0) $display("FAIL burst_claim_latency got=%b%b exp=00", devsel, trdy); else passed++;
        total++; if (ad !== 32'hAAAAAAAA || c_be !== 4'hF) $display("FAIL burst_data_phase got=%h/%b exp=aaaaaaaa/1111", ad, c_be); else passed++;
      end
      if (irdy === 1'b0 && trdy === 1'b0) begin
        xfers++;
        if (xfers == 2) burst[0] = 1'b0;
      end
      if (frame === 1'b1) break;
    end
    total++; if (xfers !== 3) $display("FAIL burst_frame_last got=%0d exp=3", xfers); else passed++;
    @(negedge clk);
    total++; if ({frame, irdy, devsel, trdy} !== 4'b1111) $display("FAIL burst_turn got=%b exp=1111", {frame, irdy, devsel, trdy}); else passed++;
    for (int w = 0; w < 3; w++) begin
      total++; if (dev1.mem[w] !== 32'hAAAAAAAA) $display("FAIL burst_mem%0d got=%h exp=aaaaaaaa", w, dev1.mem[w]); else passed++;
    end
    total++; if (dev1.mem[3] !== 32'h0) $display("FAIL burst_mem3 got=%h exp=0", dev1.mem[3]); else passed++;
    @(negedge clk);
  endtask

  task automatic test_no_device;
    int n, f0, f1;
    bit dv;
    start_txn(2, 2'd3, 1'b0, 4'hF, 32'h55555555, 1'b1);
    wait_addr(n);
    total++; if (ad !== 32'h3 || c_be !== 4'b0111) $display("FAIL nodev_addr_phase got=%h/%b exp=00000003/0111", ad, c_be); else passed++;
    f0 = 0; f1 = 0; dv = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (devsel === 1'b0) dv = 1'b1;
      if (irdy === 1'b0 && frame === 1'b0) f0++;
      else if (irdy === 1'b0) f1++;
      else break;
    end
    total++; if (dv !== 1'b0) $display("FAIL nodev_devsel got=%b exp=0", dv); else passed++;
    total++; if (f0 !== 4 || f1 !== 1) $display("FAIL nodev_abort_order got=%0d,%0d exp=4,1", f0, f1); else passed++;
    total++; if (req[2] !== 1'b1) $display("FAIL nodev_req got=%b exp=1", req[2]); else passed++;
    @(negedge clk);
    total++; if (dev2.m_frame_oe !== 1'b0 || dev2.m_irdy_oe !== 1'b0) $display("FAIL nodev_release got=%b%b exp=00", dev2.m_frame_oe, dev2.m_irdy_oe); else passed++;
    burst[2] = 1'b0;
  endtask

  task automatic test_read;
    int n;
    start_txn(2, 2'd1, 1'b1, 4'hF, 32'h0, 1'b0);
    wait_addr(n);
    total++; if (ad !== 32'h1 || c_be !== 4'b0110) $display("FAIL read_addr_phase got=%h/%b exp=00000001/0110", ad, c_be); else passed++;
    @(negedge clk);
    total++; if (devsel !== 1'b0 || trdy !== 1'b1 || irdy !== 1'b0) $display("FAIL read_turnaround got=%b%b%b exp=010", devsel, trdy, irdy); else passed++;
    @(negedge clk);
    total++; if (trdy !== 1'b0 || ad !== 32'hAAAAAAAA) $display("FAIL read_data got=%b/%h exp=0/aaaaaaaa", trdy, ad); else passed++;
    @(negedge clk);
    total++; if (dev2.last_read !== 32'hAAAAAAAA) $display("FAIL read_last_read got=%h exp=aaaaaaaa", dev2.last_read); else passed++;
    @(negedge clk);
  endtask

  task automatic test_partial_write;
    int n;
    start_txn(0, 2'd1, 1'b0, 4'b0011, 32'h12345678, 1'b0);
    wait_addr(n);
    @(negedge clk);
    total++; if (c_be !== 4'b0011 || ad !== 32'h12345678) $display("FAIL partial_data_phase got=%b/%h exp=0011/12345678", c_be, ad); else passed++;
    @(negedge clk);
    total++; if (dev1.mem[0] !== 32'hAAAA5678) $display("FAIL partial_mem0 got=%h exp=aaaa5678", dev1.mem[0]); else passed++;
    total++; if (dev1.mem[1] !== 32'hAAAAAAAA) $display("FAIL partial_mem1 got=%h exp=aaaaaaaa", dev1.mem[1]); else passed++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int n;
    start_txn(0, 2'd1, 1'b0, 4'hF, 32'h11111111, 1'b0);
    start_txn(2, 2'd0, 1'b0, 4'hF, 32'h22222222, 1'b0);
    wait_addr(n);
    total++; if (ad !== 32'h1 || req[2] !== 1'b0) $display("FAIL b2b_first_addr got=%h/%b exp=00000001/0", ad, req[2]); else passed++;
    @(negedge clk);
    total++; if (ad !== 32'h11111111 || devsel !== 1'b0) $display("FAIL b2b_first_data got=%h/%b exp=11111111/0", ad, devsel); else passed++;
    @(negedge clk);
    total++; if (frame !== 1'b1 || irdy !== 1'b1) $display("FAIL b2b_idle_gap got=%b%b exp=11", frame, irdy); else passed++;
    @(negedge clk);
    total++; if (frame !== 1'b0 || ad !== 32'h0 || c_be !== 4'b0111) $display("FAIL b2b_second_addr got=%b/%h/%b exp=0/00000000/0111", frame, ad, c_be); else passed++;
    @(negedge clk);
    total++; if (ad !== 32'h22222222 || trdy !== 1'b0) $display("FAIL b2b_second_data got=%h/%b exp=22222222/0", ad, trdy); else passed++;
    @(negedge clk);
    total++; if (dev1.mem[0] !== 32'h11111111 || dev0.mem[0] !== 32'h22222222) $display("FAIL b2b_mem got=%h/%h exp=11111111/22222222", dev1.mem[0], dev0.mem[0]); else passed++;
    @(negedge clk);
  endtask

  task automatic test_reset_midway;
    int n;
    start_txn(0, 2'd1, 1'b0, 4'hF, 32'h33333333, 1'b1);
    wait_addr(n);
    @(negedge clk);
    total++; if (devsel !== 1'b0) $display("FAIL mid_claim got=%b exp=0", devsel); else passed++;
    reset_add_n = 1'b0;
    #1;
    total++; if (req !== 3'b111 || dev0.m_frame_oe !== 1'b0 || dev1.t_devsel_oe !== 1'b0) $display("FAIL mid_release got=%b/%b/%b exp=111/0/0", req, dev0.m_frame_oe, dev1.t_devsel_oe); else passed++;
    total++; if (dev1.mem[1] !== 32'h0) $display("FAIL mid_mem_clear got=%h exp=0", dev1.mem[1]); else passed++;
    burst[0] = 1'b0;
    @(negedge clk);
    reset_add_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_self_abort;
    test_burst_write;
    test_no_device;
    test_read;
    test_partial_write;
    test_back_to_back;
    test_reset_midway;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pci_device_controller.md
Name: pci_device_controller

Overview:
- Simplified PCI-style bus agent acting as both initiator (master) and target.
- Several instances share one tri-stated bus: AD, C_BE, FRAME#, IRDY#, TRDY#, DEVSEL#.
- Each instance has a private REQ#/GNT# pair to a separate central arbiter block.
- As master it runs single or burst read/write transactions on request; as target it decodes its own 2-bit ID and serves a small internal word memory.

Parameters:
- MEM_DEPTH, 4, number of 32-bit words in the target memory; burst index wraps modulo MEM_DEPTH.
- DEVSEL_TIMEOUT, 4, clocks after the address phase without DEVSEL# before master abort.

Ports:
- clk  input  1  bus clock; all activity on the rising edge.
- reset_add_n  input  1  asynchronous active-low reset; also loads own ID from address.
- address  input  2  own ID while in reset; target ID for a transaction afterwards.
- be  input  4  byte enables (active-high) for write data phases.
- force_req  input  1  high at a rising edge starts a transaction request.
- rd_wr  input  1  0 = write, 1 = read.
- data  input  32  write data for every write data phase.
- burst  input  1  high keeps the transaction going; low makes the current data phase the last.
- ad  inout  32  multiplexed address/data.
- c_be  inout  4  command during the address phase, byte enables during data phases.
- devsel  inout  1  DEVSEL#, active-low.
- frame  inout  1  FRAME#, active-low.
- irdy  inout  1  IRDY#, active-low.
- trdy  inout  1  TRDY#, active-low.
- gnt  input  1  GNT#, active-low, from the arbiter.
- req  output  1  REQ#, active-low, to the arbiter.

Behaviour:
- Reset (reset_add_n low): own_id <= address (asynchronous); memory words cleared to 0; req = 1; all inout ports = z; master and target FSMs idle.
- Undriven shared lines are z; the bus environment provides pull-ups, so a floating line reads as deasserted.
- Master FSM states: IDLE, REQ, ADDR, DATA, TURN.
- IDLE -> REQ: force_req = 1 at an edge. Latch address, rd_wr and burst; drive req = 0.
- REQ -> ADDR: gnt = 0 and bus idle (frame = 1 and irdy = 1 sampled).
- ADDR (one clock):
  - frame = 0.
  - ad = {30'b0, target_id}.
  - c_be = 4'b0111 for a write, 4'b0110 for a read.
  - req returns to 1.
- DATA:
  - irdy = 0.
  - Write: ad = data, c_be = be.
  - Read: ad = z, c_be = be; read data is captured into an internal last_read register.
  - A transfer completes at an edge where irdy = 0 and trdy = 0.
  - While burst = 1, frame stays 0 and data phases continue.
  - frame goes 1 in the data phase where burst = 0 (last phase); the FSM moves to TURN after that phase completes.
- Master abort: devsel still 1 for DEVSEL_TIMEOUT clocks after ADDR -> frame = 1, then irdy = 1 one clock later, then TURN.
- TURN: drive frame = 1 and irdy = 1 for one clock, then release to z and return to IDLE.
- force_req while not IDLE is ignored.
- Target FSM states: T_IDLE, T_CLAIM, T_DATA, T_TURN.
- Address phase detection: first edge with frame = 0 after frame = 1.
  - ad[1:0] == own_id and c_be is 0110/0111 -> T_CLAIM; reset the word index to 0.
  - Otherwise stay in T_IDLE.
- Own-transaction exclusion: the target never claims a transaction issued by its own master.
- Write access:
  - devsel = 0 and trdy = 0 starting the clock after the address phase.
  - Each completed transfer writes ad into mem[index] byte-wise under c_be (bit i set updates byte i).
  - index increments with wrap.
- Read access:
  - devsel = 0 the clock after the address phase.
  - trdy = 0 and ad = mem[index] from the following clock (turnaround).
  - Each completed transfer increments index with wrap.
- Termination: when frame = 1 and the final transfer completes, go to T_TURN. Drive devsel = 1 and trdy = 1 for one clock, then z.
- Reset asserted mid-transaction: all outputs go z and req = 1 immediately; memory is cleared.

Test Plan:
- Reset with address = 1, release; then address = 1, rd_wr = 0, burst = 0, data = 0xAAAAAAAA, be = F, force_req pulse; arbiter grants -> one-phase write with c_be = 0111, self-claim suppressed, master abort after 4 clocks, bus returns to z.
- Two instances, IDs 0 and 1: ID0 writes a 3-word burst of 0xAAAAAAAA, be = F, to ID1 -> ID1 asserts devsel/trdy one clock after the address phase; ID1 mem[0..2] = 0xAAAAAAAA; frame deasserts on the last phase.
- Write to address 3 (no device) -> devsel stays 1; master abort; frame then irdy deassert; req = 1; FSM back in IDLE.
- ID2 reads from ID1 after the burst -> turnaround cycle; trdy = 0 one clock after devsel; ad = 0xAAAAAAAA; last_read = 0xAAAAAAAA.
- Partial write: be = 0011, data = 0x12345678 to a word holding 0xAAAAAAAA -> stored word = 0xAAAA5678.
- Two masters request in the same clock (arbiter grants one) -> transactions serialize; the second starts only after frame = 1 and irdy = 1; no bus contention (no X on ad).
